// File: rtl/pmcc_enc_pkg.sv
// Shared types and encoding helpers for the PMC coprocessor instruction encoder.
// Opcode values match the instruction decoder's bits [7:5].
package pmcc_enc_pkg;

    typedef enum logic [2:0] {
        OP_WAITT  = 3'd0,
        OP_JUMP   = 3'd1,
        OP_LOOP   = 3'd2,
        OP_STOREB = 3'd3,
        OP_STORE  = 3'd4
    } pmcc_enc_op_t;

    localparam logic [2:0] OPC_STORE  = 3'b110;
    localparam logic [2:0] OPC_STOREB = 3'b100;
    localparam logic [2:0] OPC_LOOP   = 3'b010;
    localparam logic [2:0] OPC_JUMP   = 3'b001;
    localparam logic [2:0] OPC_WAITT  = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_INSTR,
        S_WR_ARG0,
        S_WR_ARG1
    } pmcc_enc_state_t;

    // Total words written (instruction + operands); 0 marks an illegal op.
    function automatic logic [1:0] op_word_count(input logic [2:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (pmcc_enc_op_t'(op))
            OP_WAITT:            n = 2'd1;
            OP_JUMP, OP_LOOP:    n = 2'd2;
            OP_STOREB, OP_STORE: n = 2'd3;
            default:             n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] op_opcode(input logic [2:0] op);
        logic [2:0] opc;
        opc = OPC_WAITT;
        case (pmcc_enc_op_t'(op))
            OP_WAITT:  opc = OPC_WAITT;
            OP_JUMP:   opc = OPC_JUMP;
            OP_LOOP:   opc = OPC_LOOP;
            OP_STOREB: opc = OPC_STOREB;
            OP_STORE:  opc = OPC_STORE;
            default:   opc = OPC_WAITT;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/pmcc_instr_encoder_word_gen.sv
// Combinational command -> instruction word translation: opcode placement,
// word count and legality of the requested op.
module pmcc_instr_word_gen
    import pmcc_enc_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [23:0] imm,
    output logic [31:0] instr,
    output logic [1:0]  nwords,
    output logic        legal
);

    logic [2:0] opc;

    always_comb begin
        opc    = op_opcode(op);
        nwords = op_word_count(op);
        legal  = (nwords != 2'd0);
        instr  = {imm, opc, 5'b0_0000};
    end

endmodule

// File: rtl/pmcc_instr_encoder.sv
// PMC coprocessor instruction encoder: writes encoded commands into code RAM.
// Optional macro PMCC_ENCODER_OVERFLOW_CHECK_EN drops commands that would wrap.
module pmcc_instr_encoder
    import pmcc_enc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [23:0]           cmd_imm,
    input  logic [31:0]           cmd_arg0,
    input  logic [31:0]           cmd_arg1,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic                  busy,
    output logic                  error
);

    pmcc_enc_state_t state_q, state_d;

    logic                  rdy_en_q;
    logic [31:0]           arg0_q, arg1_q;
    logic [1:0]            nwords_q;

    logic [31:0]           gen_instr;
    logic [1:0]            gen_nwords;
    logic                  gen_legal;

    logic                  accept, fits, take, gnt_ok;
    logic [ADDR_WIDTH-1:0] ptr_inc;

    logic                  req_d, err_d;
    logic [ADDR_WIDTH-1:0] addr_d, ptr_d;
    logic [31:0]           wdata_d;

    pmcc_instr_word_gen u_word_gen (
        .op     (cmd_op),
        .imm    (cmd_imm),
        .instr  (gen_instr),
        .nwords (gen_nwords),
        .legal  (gen_legal)
    );

    // rdy_en_q keeps cmd_ready low while reset is asserted.
    assign cmd_ready = rdy_en_q && (state_q == S_IDLE) && !load_addr;
    assign accept    = cmd_valid && cmd_ready;
    assign gnt_ok    = mem_req && mem_gnt;
    assign ptr_inc   = wr_ptr + ADDR_WIDTH'(1);
    assign busy      = (state_q != S_IDLE);

`ifdef PMCC_ENCODER_OVERFLOW_CHECK_EN
    logic [ADDR_WIDTH:0] end_ptr;
    assign end_ptr = {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(gen_nwords);
    assign fits    = (end_ptr <= {1'b1, {ADDR_WIDTH{1'b0}}});
`else
    assign fits    = 1'b1;
`endif

    assign take = accept && gen_legal && fits;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (take) state_d = S_WR_INSTR;
            S_WR_INSTR: if (gnt_ok) state_d = (nwords_q == 2'd1) ? S_IDLE : S_WR_ARG0;
            S_WR_ARG0:  if (gnt_ok) state_d = (nwords_q == 2'd2) ? S_IDLE : S_WR_ARG1;
            S_WR_ARG1:  if (gnt_ok) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of the registered write port: the following word is loaded
    // in the same cycle the current one is granted, so writes can stream.
    always_comb begin
        req_d   = mem_req;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        ptr_d   = wr_ptr;
        err_d   = error;
        case (state_q)
            S_IDLE: begin
                if (load_addr) begin
                    ptr_d = start_addr;
                    err_d = 1'b0;
                end else if (take) begin
                    req_d   = 1'b1;
                    addr_d  = wr_ptr;
                    wdata_d = gen_instr;
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            S_WR_INSTR: begin
                if (gnt_ok) begin
                    ptr_d = ptr_inc;
                    if (nwords_q == 2'd1) begin
                        req_d = 1'b0;
                    end else begin
                        addr_d  = ptr_inc;
                        wdata_d = arg0_q;
                    end
                end
            end
            S_WR_ARG0: begin
                if (gnt_ok) begin
                    ptr_d = ptr_inc;
                    if (nwords_q == 2'd2) begin
                        req_d = 1'b0;
                    end else begin
                        addr_d  = ptr_inc;
                        wdata_d = arg1_q;
                    end
                end
            end
            S_WR_ARG1: begin
                if (gnt_ok) begin
                    ptr_d = ptr_inc;
                    req_d = 1'b0;
                end
            end
            default: req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rdy_en_q  <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ptr    <= '0;
            error     <= 1'b0;
            arg0_q    <= '0;
            arg1_q    <= '0;
            nwords_q  <= '0;
        end else begin
            state_q   <= state_d;
            rdy_en_q  <= 1'b1;
            mem_req   <= req_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            wr_ptr    <= ptr_d;
            error     <= err_d;
            if (take) begin
                arg0_q   <= cmd_arg0;
                arg1_q   <= cmd_arg1;
                nwords_q <= gen_nwords;
            end
        end
    end

endmodule

// File: tb/tb_pmcc_instr_encoder.sv
// Directed self-checking bench for pmcc_instr_encoder (ADDR_WIDTH=8).
// Follows PMCC_ENCODER_OVERFLOW_CHECK_EN for the wrap-around expectations.
module tb_pmcc_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_addr;
    logic [7:0]  start_addr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [23:0] cmd_imm;
    logic [31:0] cmd_arg0, cmd_arg1;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic [7:0]  wr_ptr;
    logic        busy;
    logic        error;

    int tests  = 0;
    int errors = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    pmcc_instr_encoder #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_addr  (load_addr),
        .start_addr (start_addr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_imm    (cmd_imm),
        .cmd_arg0   (cmd_arg0),
        .cmd_arg1   (cmd_arg1),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .wr_ptr     (wr_ptr),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input int i, input logic [7:0] a, input logic [31:0] d);
        check("wr_present", 64'(wa.size() > i), 1);
        if (wa.size() > i) begin
            check("wr_addr", wa[i], a);
            check("wr_data", wd[i], d);
        end
    endtask

    task automatic load(input logic [7:0] a);
        @(negedge clk);
        load_addr  = 1'b1;
        start_addr = a;
        #1 check("ld_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1 load_addr = 1'b0;
    endtask

    // Returns 1 time unit after the accepting clock edge.
    task automatic send_cmd(input logic [2:0] op, input logic [23:0] imm,
                            input logic [31:0] a0, input logic [31:0] a1);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        cmd_arg0  = a0;
        cmd_arg1  = a1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; load_addr = 1'b0; start_addr = '0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_imm = '0; cmd_arg0 = '0; cmd_arg1 = '0; mem_gnt = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ptr", wr_ptr, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // WAITT, single word
        load(8'h10);
        check("ld_ptr", wr_ptr, 8'h10);
        mem_gnt = 1'b1;
        wa.delete(); wd.delete();
        send_cmd(3'd0, 24'h00ABCD, 32'h0, 32'h0);
        @(negedge clk);
        check("waitt_ready_c1", cmd_ready, 0);
        check("waitt_busy_c1", busy, 1);
        check("waitt_req_c1", mem_req, 1);
        @(negedge clk);
        check("waitt_ready_c2", cmd_ready, 1);
        check("waitt_busy_c2", busy, 0);
        check("waitt_nwr", wa.size(), 1);
        check_write(0, 8'h10, 32'h00ABCD00);
        check("waitt_ptr", wr_ptr, 8'h11);

        // STORE, three words back-to-back
        wa.delete(); wd.delete();
        send_cmd(3'd4, 24'h0, 32'hDEADBEEF, 32'h12345678);
        wait_idle();
        check("store_nwr", wa.size(), 3);
        check_write(0, 8'h11, 32'h000000C0);
        check_write(1, 8'h12, 32'hDEADBEEF);
        check_write(2, 8'h13, 32'h12345678);
        check("store_ptr", wr_ptr, 8'h14);

        // LOOP with 3-cycle grant stall per word
        mem_gnt = 1'b0;
        wa.delete(); wd.delete();
        send_cmd(3'd2, 24'h000005, 32'hCAFEF00D, 32'h0);
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                check("stall_req", mem_req, 1);
                check("stall_addr", mem_addr, (k == 0) ? 8'h14 : 8'h15);
                check("stall_data", mem_wdata, (k == 0) ? 32'h00000540 : 32'hCAFEF00D);
                check("stall_busy", busy, 1);
            end
            @(posedge clk);
            #1 mem_gnt = 1'b1;
            @(posedge clk);
            #1 mem_gnt = 1'b0;
        end
        @(negedge clk);
        check("loop_busy_end", busy, 0);
        check("loop_req_end", mem_req, 0);
        check("loop_nwr", wa.size(), 2);
        check_write(0, 8'h14, 32'h00000540);
        check_write(1, 8'h15, 32'hCAFEF00D);
        check("loop_ptr", wr_ptr, 8'h16);

        // Illegal op: accepted, flagged, nothing written
        mem_gnt = 1'b1;
        wa.delete(); wd.delete();
        send_cmd(3'd7, 24'h111111, 32'h1, 32'h2);
        @(negedge clk);
        check("ill_req", mem_req, 0);
        check("ill_busy", busy, 0);
        check("ill_error", error, 1);
        check("ill_nwr", wa.size(), 0);
        check("ill_ptr", wr_ptr, 8'h16);
        load(8'hFE);
        check("ld_clr_error", error, 0);
        check("ld_ptr_fe", wr_ptr, 8'hFE);

        // STOREB at the top of the address space
        wa.delete(); wd.delete();
        send_cmd(3'd3, 24'h123456, 32'h11111111, 32'h22222222);
        wait_idle();
`ifdef PMCC_ENCODER_OVERFLOW_CHECK_EN
        check("ovf_nwr", wa.size(), 0);
        check("ovf_error", error, 1);
        check("ovf_ptr", wr_ptr, 8'hFE);
`else
        check("wrap_nwr", wa.size(), 3);
        check_write(0, 8'hFE, 32'h12345680);
        check_write(1, 8'hFF, 32'h11111111);
        check_write(2, 8'h00, 32'h22222222);
        check("wrap_ptr", wr_ptr, 8'h01);
        check("wrap_error", error, 0);
`endif

        // Asynchronous reset during WR_ARG0
        mem_gnt = 1'b0;
        load(8'h40);
        send_cmd(3'd4, 24'h0, 32'hAAAA5555, 32'h5555AAAA);
        mem_gnt = 1'b1;
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        @(negedge clk);
        check("arg0_req", mem_req, 1);
        check("arg0_addr", mem_addr, 8'h41);
        check("arg0_data", mem_wdata, 32'hAAAA5555);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_ptr", wr_ptr, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_gnt = 1'b1;
        wa.delete(); wd.delete();
        send_cmd(3'd1, 24'h000777, 32'hA5A5A5A5, 32'h0);
        wait_idle();
        check("jump_nwr", wa.size(), 2);
        check_write(0, 8'h00, 32'h00077720);
        check_write(1, 8'h01, 32'hA5A5A5A5);
        check("jump_ptr", wr_ptr, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
